// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder.
//   mem_type_t : access size/extension encoding carried on MemTypeM
//   state_t    : responder FSM states
//   req_t      : request captured at acceptance and held for the access
package mem_pkg;

    typedef enum logic [1:0] {
        MT_WORD  = 2'b00,
        MT_HALF  = 2'b01,   // signed halfword
        MT_BYTE  = 2'b10,   // signed byte
        MT_UBYTE = 2'b11    // unsigned byte
    } mem_type_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef struct packed {
        logic      wr;      // store (wins when load and store are both requested)
        mem_type_t mtype;
        logic [31:0] addr;  // byte address
        logic [31:0] wdata; // right-justified store data
    } req_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage <-> data-memory bus.
//   master : pipeline side, drives the request, receives data/stall/strobes
//   slave  : responder side
interface data_mem_responder_if;
    logic        MemReadM;
    logic        MemWriteM;
    logic [1:0]  MemTypeM;
    logic [31:0] ALUResultM;
    logic [31:0] ReadData2M;
    logic [31:0] MemReadDataM;
    logic        Stall;
    logic        RespValid;
    logic        AlignErr;

    modport master (
        output MemReadM, MemWriteM, MemTypeM, ALUResultM, ReadData2M,
        input  MemReadDataM, Stall, RespValid, AlignErr
    );

    modport slave (
        input  MemReadM, MemWriteM, MemTypeM, ALUResultM, ReadData2M,
        output MemReadDataM, Stall, RespValid, AlignErr
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for one access.
//   mtype, offset : access size and addr[1:0]
//   wdata         : right-justified store data
//   rword         : addressed memory word
//   be            : byte-enable mask (all zero when misaligned)
//   wshift        : store data replicated onto every candidate lane
//   rdata         : extracted and extended load data (zero when misaligned)
//   misalign      : word not on a 4-byte boundary or half on an odd address
module mem_lane_align
    import mem_pkg::*;
(
    input  mem_type_t   mtype,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wshift,
    output logic [31:0] rdata,
    output logic        misalign
);
    logic [15:0] half;
    logic [7:0]  byte_v;

    always_comb begin
        half     = offset[1] ? rword[31:16] : rword[15:0];
        byte_v   = rword[{offset, 3'b000} +: 8];
        be       = '0;
        wshift   = '0;
        rdata    = '0;
        misalign = 1'b0;
        case (mtype)
            MT_WORD: begin
                misalign = (offset != 2'b00);
                be       = 4'hF;
                wshift   = wdata;
                rdata    = rword;
            end
            MT_HALF: begin
                misalign = offset[0];
                be       = offset[1] ? 4'b1100 : 4'b0011;
                wshift   = {2{wdata[15:0]}};
                rdata    = {{16{half[15]}}, half};
            end
            MT_BYTE: begin
                be     = 4'b0001 << offset;
                wshift = {4{wdata[7:0]}};
                rdata  = {{24{byte_v[7]}}, byte_v};
            end
            MT_UBYTE: begin
                be     = 4'b0001 << offset;
                wshift = {4{wdata[7:0]}};
                rdata  = {24'h0, byte_v};
            end
            default: ;
        endcase
        // a misaligned access neither writes nor returns data
        if (misalign) begin
            be    = '0;
            rdata = '0;
        end
    end
endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the MEM stage of the 5-stage pipeline.
//   Clk, Reset : rising-edge clock, synchronous active-high reset
//   bus        : slave side of data_mem_responder_if (request in,
//                MemReadDataM/Stall/RespValid/AlignErr out)
// One access at a time; Stall is held for LATENCY cycles (the accept cycle
// included), then a one-cycle RESP returns RespValid/AlignErr.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic Clk,
    input  logic Reset,
    data_mem_responder_if.slave bus
);
    state_t            state, state_nx;
    logic [3:0]        cnt;
    req_t              req_q, req_live, req_cur;
    logic              req_valid, accept, done;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       rword, wshift, rdata, rdata_q;
    logic [3:0]        be;
    logic              misalign;
    logic              unused_addr_hi;
    logic [31:0]       mem [DEPTH];

    assign req_valid = bus.MemReadM | bus.MemWriteM;
    assign accept    = (state == ST_IDLE) && req_valid;
    assign req_live  = '{wr: bus.MemWriteM, mtype: mem_type_t'(bus.MemTypeM),
                         addr: bus.ALUResultM, wdata: bus.ReadData2M};
    // live inputs only matter in the accept cycle; afterwards the latched copy
    assign req_cur   = (state == ST_IDLE) ? req_live : req_q;

    // cnt = stall cycles still owed after the current one; the accept cycle
    // is the first stall cycle, so LATENCY==1 completes at the accept edge
    assign done = ((state == ST_BUSY) && (cnt == 4'd1)) || ((LATENCY == 1) && accept);

    assign idx            = req_cur.addr[ADDR_W+1:2];
    assign unused_addr_hi = ^req_cur.addr[31:ADDR_W+2];
    assign rword          = mem[idx];

    mem_lane_align u_align (
        .mtype   (req_cur.mtype),
        .offset  (req_cur.addr[1:0]),
        .wdata   (req_cur.wdata),
        .rword   (rword),
        .be      (be),
        .wshift  (wshift),
        .rdata   (rdata),
        .misalign(misalign)
    );

    // FSM: state register
    always_ff @(posedge Clk) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (req_valid) state_nx = (LATENCY == 1) ? ST_RESP : ST_BUSY;
            ST_BUSY: if (done)      state_nx = ST_RESP;
            ST_RESP:                state_nx = ST_IDLE;
            default:                state_nx = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.Stall     = accept || (state == ST_BUSY);
        bus.RespValid = (state == ST_RESP);
        bus.AlignErr  = (state == ST_RESP) && misalign;
    end

    assign bus.MemReadDataM = rdata_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt     <= '0;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                req_q <= req_live;
                cnt   <= 4'(LATENCY - 1);
            end else if ((state == ST_BUSY) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            // stores and misaligned accesses return zero
            if (done) rdata_q <= (req_cur.wr || misalign) ? 32'h0 : rdata;
        end
    end

    // storage is not reset; a store completing under Reset is dropped
    always_ff @(posedge Clk) begin
        if (!Reset && done && req_cur.wr) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wshift[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
    import mem_pkg::*;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        rst2, rst3;
    logic        sel;            // 0 -> LATENCY=2 instance, 1 -> LATENCY=3 instance
    logic        rd, wr;
    logic [1:0]  mtype;
    logic [31:0] addr, wdata;

    data_mem_responder_if bus2();
    data_mem_responder_if bus3();

    assign bus2.MemReadM   = rd & ~sel;
    assign bus2.MemWriteM  = wr & ~sel;
    assign bus2.MemTypeM   = mtype;
    assign bus2.ALUResultM = addr;
    assign bus2.ReadData2M = wdata;
    assign bus3.MemReadM   = rd & sel;
    assign bus3.MemWriteM  = wr & sel;
    assign bus3.MemTypeM   = mtype;
    assign bus3.ALUResultM = addr;
    assign bus3.ReadData2M = wdata;

    logic        stall_o, resp_o, aerr_o;
    logic [31:0] rdata_o;
    assign stall_o = sel ? bus3.Stall        : bus2.Stall;
    assign resp_o  = sel ? bus3.RespValid    : bus2.RespValid;
    assign aerr_o  = sel ? bus3.AlignErr     : bus2.AlignErr;
    assign rdata_o = sel ? bus3.MemReadDataM : bus2.MemReadDataM;

    data_mem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(2)) dut2 (
        .Clk(Clk), .Reset(rst2), .bus(bus2));
    data_mem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(3)) dut3 (
        .Clk(Clk), .Reset(rst3), .bus(bus3));

    int checks   = 0;
    int failures = 0;

    // byte-addressed reference memories (4 KiB each, address wraps mod 4096)
    bit [7:0] ref2 [4096];
    bit [7:0] ref3 [4096];

    task automatic model(input bit s, input bit w, input logic [1:0] t,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] exp_d, output bit exp_err);
        int          size, off;
        logic [11:0] b;
        logic [31:0] v;
        size    = (t == 2'b00) ? 4 : (t == 2'b01) ? 2 : 1;
        off     = int'(a[1:0]);
        exp_err = (off % size) != 0;
        exp_d   = 32'h0;
        b       = a[11:0];
        if (exp_err) return;
        if (w) begin
            for (int i = 0; i < size; i++) begin
                if (s) ref3[12'(b + i)] = d[8*i +: 8];
                else   ref2[12'(b + i)] = d[8*i +: 8];
            end
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++)
                v = v | (32'(s ? ref3[12'(b + i)] : ref2[12'(b + i)]) << (8*i));
            if (t != 2'b11 && size < 4 && v[8*size-1])
                v = v - (32'd1 << (8*size));
            exp_d = v;
        end
    endtask

    // Runs one access from posedge+1 and returns at posedge+1 with the DUT idle.
    task automatic access(input bit s, input bit r, input bit w, input logic [1:0] t,
                          input logic [31:0] a, input logic [31:0] d,
                          input string name, output logic [31:0] obs_d);
        int          lat, stalls, cyc;
        bit          got;
        logic        obs_err, obs_stall;
        logic [31:0] exp_d;
        bit          exp_err;
        lat = s ? 3 : 2;
        stalls = 0; got = 0; obs_d = 'x; obs_err = 1'bx; obs_stall = 1'bx;
        model(s, w, t, a, d, exp_d, exp_err);
        sel = s; rd = r; wr = w; mtype = t; addr = a; wdata = d;
        for (cyc = 0; cyc < 20; cyc++) begin
            @(negedge Clk);
            if (resp_o === 1'b1) begin
                got = 1; obs_d = rdata_o; obs_err = aerr_o; obs_stall = stall_o;
                break;
            end
            if (stall_o === 1'b1) stalls++;
            @(posedge Clk); #1;
            // request dropped, other inputs scrambled: only latched values count
            rd = 0; wr = 0; mtype = 2'($urandom); addr = $urandom; wdata = $urandom;
        end
        checks++;
        if (!got || cyc != lat || stalls != lat || obs_stall !== 1'b0) begin
            failures++;
            $display("FAIL %s timing: resp_cycle=%0d stalls=%0d resp_stall=%b, required %0d/%0d/0",
                     name, cyc, stalls, obs_stall, lat, lat);
        end
        checks++;
        if (obs_d !== exp_d) begin
            failures++;
            $display("FAIL %s data: got %h required %h", name, obs_d, exp_d);
        end
        checks++;
        if (obs_err !== exp_err) begin
            failures++;
            $display("FAIL %s align_err: got %b required %b", name, obs_err, exp_err);
        end
        @(posedge Clk); #1;
        @(negedge Clk);
        checks++;
        if (resp_o !== 1'b0 || stall_o !== 1'b0 || aerr_o !== 1'b0) begin
            failures++;
            $display("FAIL %s strobe_width: resp=%b stall=%b aerr=%b required 0/0/0",
                     name, resp_o, stall_o, aerr_o);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_reset;
        sel = 0; rd = 0; wr = 0; mtype = 2'b00; addr = '0; wdata = '0;
        rst2 = 1; rst3 = 1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            checks++;
            if (stall_o !== 1'b0 || resp_o !== 1'b0 || aerr_o !== 1'b0 || rdata_o !== 32'h0) begin
                failures++;
                $display("FAIL reset_state dut%0d: stall=%b resp=%b aerr=%b data=%h required 0/0/0/0",
                         s + 2, stall_o, resp_o, aerr_o, rdata_o);
            end
        end
        sel = 0;
        @(posedge Clk); #1;
        rst2 = 0; rst3 = 0;
    endtask

    task automatic directed_load(input logic [1:0] t, input logic [31:0] a,
                                 input logic [31:0] lit, input string name);
        logic [31:0] d;
        access(0, 1, 0, t, a, $urandom, name, d);
        checks++;
        if (d !== lit) begin
            failures++;
            $display("FAIL %s literal: got %h required %h", name, d, lit);
        end
    endtask

    task automatic test_directed;
        logic [31:0] d;
        access(0, 0, 1, MT_WORD, 32'h10, 32'hDEADBEEF, "st_word_10", d);
        directed_load(MT_WORD,  32'h10, 32'hDEADBEEF, "ld_word_10");
        access(0, 0, 1, MT_BYTE, 32'h11, 32'hABCDEF80, "st_byte_11", d);
        directed_load(MT_BYTE,  32'h11, 32'hFFFFFF80, "ld_sbyte_11");
        directed_load(MT_UBYTE, 32'h11, 32'h00000080, "ld_ubyte_11");
        directed_load(MT_WORD,  32'h10, 32'hDEAD80EF, "ld_word_after_byte");
        access(0, 0, 1, MT_HALF, 32'h12, 32'h55551234, "st_half_12", d);
        directed_load(MT_HALF,  32'h12, 32'h00001234, "ld_half_12");
        directed_load(MT_WORD,  32'h10, 32'h123480EF, "ld_word_after_half");
        access(0, 0, 1, MT_WORD, 32'h13, 32'hFFFFFFFF, "st_word_misaligned", d);
        directed_load(MT_WORD,  32'h10, 32'h123480EF, "ld_word_after_misaligned");
        directed_load(MT_HALF,  32'h11, 32'h00000000, "ld_half_misaligned");
        // load+store together is a store, returns zero
        access(0, 1, 1, MT_WORD, 32'hFFFF_F014, 32'h0BADF00D, "st_both_wrap", d);
        directed_load(MT_WORD,  32'h14, 32'h0BADF00D, "ld_word_wrap");
    endtask

    task automatic test_random;
        logic [31:0] d, a;
        int          kind;
        for (int i = 0; i < 16; i++) begin
            a = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'(i*4));
            access(0, 0, 1, MT_WORD, a, $urandom, "rnd_init", d);
        end
        for (int i = 0; i < 60; i++) begin
            a    = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'($urandom_range(0, 63)));
            kind = $urandom_range(0, 2);
            access(0, kind != 1, kind != 0, 2'($urandom_range(0, 3)), a, $urandom, "rnd_access", d);
        end
    endtask

    task automatic test_back_to_back;
        sel = 1; rd = 1; wr = 0; mtype = MT_WORD; addr = 32'h200; wdata = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            checks++;
            if (stall_o !== ((i % 4) != 3) || resp_o !== ((i % 4) == 3)) begin
                failures++;
                $display("FAIL back_to_back cycle %0d: stall=%b resp=%b required %b/%b",
                         i, stall_o, resp_o, (i % 4) != 3, (i % 4) == 3);
            end
            @(posedge Clk); #1;
        end
        rd = 0;
        @(posedge Clk); #1;
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        access(1, 0, 1, MT_WORD, 32'h40, 32'hCAFEF00D, "mid_prefill", d);
        sel = 1; rd = 0; wr = 1; mtype = MT_WORD; addr = 32'h40; wdata = 32'h11111111;
        @(posedge Clk); #1;          // now in the first BUSY cycle
        rst3 = 1; wr = 0;
        @(posedge Clk); #1;
        rst3 = 0;
        @(negedge Clk);
        checks++;
        if (stall_o !== 1'b0 || resp_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_idle: stall=%b resp=%b required 0/0", stall_o, resp_o);
        end
        @(posedge Clk); #1;
        access(1, 1, 0, MT_WORD, 32'h40, 32'h0, "mid_reload", d);
        checks++;
        if (d !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL reset_mid_dropped_store: got %h required %h", d, 32'hCAFEF00D);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
